uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, selectable data width, parity and stop-bit count. Sits between the command/telemetry logic and the serial TX pin. Replaces the fixed 8N1, single-byte transmitter: callers can queue several bytes and frames go out back-to-back without idle gaps.

## Interface
- CLK_DIV, 2604: clk cycles per bit (19200 baud at 50 MHz); legal ≥ 2
- DATA_BITS, 8: data bits per frame; legal 5..9
- PARITY, PAR_NONE: parity mode from `uart_pkg::parity_t` (PAR_NONE, PAR_EVEN, PAR_ODD)
- STOP_BITS, 1: stop bits per frame; legal 1 or 2
- FIFO_DEPTH, 4: queued words; power of 2, ≥ 2
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- trmt  input  1  push tx_data into FIFO; accepted only when tx_rdy=1
- tx_data  input  DATA_BITS  word to send, LSB first
- tx_rdy  output  1  FIFO not full
- TX  output  1  serial line, idle high, registered
- tx_done  output  1  one-cycle pulse when a frame's last stop bit ends
- busy  output  1  frame in progress or FIFO non-empty
- fifo_cnt  output  $clog2(FIFO_DEPTH+1)  words queued
- ovf  output  1  sticky: trmt arrived while tx_rdy=0

## Operation
- Reset values: TX=1, tx_done=0, busy=0, fifo_cnt=0, tx_rdy=1, ovf=0, state IDLE.
- Frame: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Parity: PAR_EVEN bit = XOR of data bits; PAR_ODD bit = inverted XOR.
- Push: trmt && tx_rdy writes tx_data at that edge. trmt && !tx_rdy drops the word and sets ovf. ovf clears only on rst.
- A simultaneous pop does not free space for a push in the same cycle. tx_rdy is derived from the current count.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. That edge pops the FIFO and loads the shifter.
  - START → DATA after one bit time.
  - DATA → PARITY, or STOP if PAR_NONE, after DATA_BITS bit times.
  - PARITY → STOP after one bit time.
  - STOP ends after STOP_BITS bit times and pulses tx_done.
    - FIFO non-empty: go directly to START, popping the next word at the same edge. No idle cycle between frames.
    - FIFO empty: go to IDLE.
- Baud counter: width $clog2(CLK_DIV), runs 0..CLK_DIV-1 while not IDLE and wraps. The wrap edge advances the bit. Every bit lasts exactly CLK_DIV cycles.
- Bit counter: counts data bits and stop bits, cleared on every state entry.

## Timing
- trmt sampled at edge N with FIFO empty and IDLE: word is in the FIFO after N, and TX falls after edge N+1.
- Frame length: CLK_DIV × (1 + DATA_BITS + (PARITY≠PAR_NONE) + STOP_BITS) cycles. tx_done is high for the cycle following the last stop-bit edge.
- Back-to-back: the next start bit begins on the same edge that ends the previous stop bit.
- fifo_cnt and tx_rdy update on the push/pop edge.
- rst mid-frame: on the next edge TX=1, FIFO emptied, all counters zeroed, FSM IDLE, ovf cleared, no tx_done pulse.

## Structure
- `uart_pkg`: parity_t enum, tx_state_t enum (IDLE..STOP), and a parity-bit function.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - synchronous-reset circular buffer with push/pop/full/empty/count;
  - pointers one bit wider than $clog2(DEPTH) for full/empty detection;
  - reusable by the planned UART receiver.
- Top level holds the FSM, baud counter, bit counter and shifter.

## Test plan
Sim uses CLK_DIV=4.
- 8N1, push 0xA5 → TX = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). tx_done pulses once, busy drops next cycle.
- 8E1, 0xA5 → parity bit 0. 8O1, 0xA5 → parity bit 1. Frame is 44 cycles.
- 7N2 (DATA_BITS=7), push 0x41 → TX = 0,1,0,0,0,0,0,1,1,1. tx_done at cycle 40.
- FIFO_DEPTH=4, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles:
  - first pop frees a slot before the fifth push, so 0x55 is accepted and ovf stays 0;
  - a sixth push while fifo_cnt=4 → tx_rdy=0, word dropped, ovf=1;
  - five frames go out with zero idle cycles between stop and start bits, giving five tx_done pulses 40 cycles apart.
- Assert rst during data bit 3 with 2 words queued → next edge TX=1, fifo_cnt=0, busy=0. No further frames, no tx_done pulse.
- trmt held high continuously with the FIFO full → only one word is accepted per freed slot, and fifo_cnt never exceeds 4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, transmitter FSM states and the parity-bit helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Callers zero-extend their word to 9 bits; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input parity_t mode);
    logic x;
    x = ^data;
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side handshake and status bundle of the queued UART transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);

  logic                               trmt;
  logic [DATA_BITS-1:0]               tx_data;
  logic                               tx_rdy;
  logic                               tx_done;
  logic                               busy;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_cnt;
  logic                               ovf;

  modport master (
    output trmt, tx_data,
    input  tx_rdy, tx_done, busy, fifo_cnt, ovf
  );

  modport slave (
    input  trmt, tx_data,
    output tx_rdy, tx_done, busy, fifo_cnt, ovf
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous-reset circular buffer; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; reset empties the buffer by re-aligning both pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Queued UART transmitter: words pushed into a small FIFO are serialised as
// start / data (LSB first) / optional parity / stop frames, back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLK_DIV    = 2604,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus,
  output logic           TX
);

  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t             state;
  tx_state_t             state_nxt;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BAUD_W-1:0]     baud_nxt;
  logic [3:0]            bit_cnt;
  logic [3:0]            bit_nxt;
  logic [DATA_BITS-1:0]  shifter;
  logic [DATA_BITS-1:0]  shifter_nxt;
  logic                  par_bit;
  logic                  par_nxt;
  logic                  tx_nxt;
  logic                  done_nxt;
  logic                  tx_done_q;
  logic                  ovf_q;
  logic                  wrap;
  logic                  push;
  logic                  pop;
  logic [DATA_BITS-1:0]  fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  // A full FIFO refuses the word even if a pop happens on the same edge.
  assign push        = bus.trmt && !fifo_full;
  assign bus.tx_rdy  = !fifo_full;
  assign bus.tx_done = tx_done_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = (state != IDLE) || !fifo_empty;
  assign wrap        = (baud_cnt == BAUD_LAST);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.fifo_cnt)
  );

  // Next-state, counter and output decode; a frame start always pops and loads the shifter.
  always_comb begin
    state_nxt   = state;
    bit_nxt     = bit_cnt;
    shifter_nxt = shifter;
    par_nxt     = par_bit;
    pop         = 1'b0;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt   = START;
          pop         = 1'b1;
          shifter_nxt = fifo_dout;
          par_nxt     = parity_bit(9'(fifo_dout), PARITY);
        end
      end
      START: begin
        if (wrap) state_nxt = DATA;
      end
      DATA: begin
        if (wrap) begin
          if (bit_cnt == DATA_LAST) begin
            state_nxt = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end else begin
            bit_nxt     = bit_cnt + 4'd1;
            shifter_nxt = shifter >> 1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (wrap) state_nxt = STOP;
      end
      STOP: begin
        if (wrap) begin
          if (bit_cnt == STOP_LAST) begin
            done_nxt = 1'b1;
            if (!fifo_empty) begin
              state_nxt   = START;
              pop         = 1'b1;
              shifter_nxt = fifo_dout;
              par_nxt     = parity_bit(9'(fifo_dout), PARITY);
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) bit_nxt = '0;

    baud_nxt = (state == IDLE || wrap) ? '0 : baud_cnt + BAUD_ONE;

    case (state_nxt)
      START:            tx_nxt = 1'b0;
      DATA:             tx_nxt = shifter_nxt[0];
      uart_pkg::PARITY: tx_nxt = par_nxt;
      default:          tx_nxt = 1'b1;
    endcase
  end

  // State, counters, registered line output and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      par_bit   <= 1'b0;
      TX        <= 1'b1;
      tx_done_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shifter   <= shifter_nxt;
      par_bit   <= par_nxt;
      TX        <= tx_nxt;
      tx_done_q <= done_nxt;
      ovf_q     <= ovf_q | (bus.trmt & fifo_full);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for the queued UART transmitter: a frame-level reference model of the
// 8N1 instance checked every cycle, plus literal frames for parity/stop variants.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FLEN    = CLK_DIV * 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       aux_trmt = 1'b0;
  logic [7:0] aux_data8 = 8'h00;
  logic [6:0] aux_data7 = 7'h00;
  logic       tx_m, tx_e, tx_o, tx_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_m ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_e ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_o ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(DEPTH)) if_s ();

  assign if_m.trmt    = trmt;
  assign if_m.tx_data = tx_data;
  assign if_e.trmt    = aux_trmt;
  assign if_e.tx_data = aux_data8;
  assign if_o.trmt    = aux_trmt;
  assign if_o.tx_data = aux_data8;
  assign if_s.trmt    = aux_trmt;
  assign if_s.tx_data = aux_data7;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_m (.clk(clk), .rst(rst), .bus(if_m), .TX(tx_m));
  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_e (.clk(clk), .rst(rst), .bus(if_e), .TX(tx_e));
  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_o (.clk(clk), .rst(rst), .bus(if_o), .TX(tx_o));
  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
    dut_s (.clk(clk), .rst(rst), .bus(if_s), .TX(tx_s));

  // Reference model state: queued words plus the frame currently on the line.
  bit         model_ok = 1'b0;
  int         mq[$];
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_done = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_n;
  bit         m_rdy;
  logic [9:0] cmp_frame;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] w);
    return {1'b1, w, 1'b0};
  endfunction

  // Model update on each rising edge, from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_done   = 1'b0;
      m_ovf    = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_n    = mq.size();
      m_rdy  = (m_n < DEPTH);
      m_done = 1'b0;
      if (m_active) begin
        if (m_pos == FLEN - 1) begin
          m_done = 1'b1;
          if (m_n > 0) begin
            m_cur = 8'(mq.pop_front());
            m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end else if (m_n > 0) begin
        m_cur    = 8'(mq.pop_front());
        m_pos    = 0;
        m_active = 1'b1;
      end
      if (trmt) begin
        if (m_rdy) mq.push_back(int'(tx_data));
        else       m_ovf = 1'b1;
      end
    end
  end

  // Every falling edge: main DUT outputs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      cmp_frame = frame_of(m_cur);
      checkOutput("tx",       32'(tx_m),          m_active ? 32'(cmp_frame[m_pos / CLK_DIV]) : 32'd1);
      checkOutput("tx_done",  32'(if_m.tx_done),  32'(m_done));
      checkOutput("busy",     32'(if_m.busy),     32'(m_active || mq.size() > 0));
      checkOutput("fifo_cnt", 32'(if_m.fifo_cnt), 32'(mq.size()));
      checkOutput("tx_rdy",   32'(if_m.tx_rdy),   32'(mq.size() < DEPTH));
      checkOutput("ovf",      32'(if_m.ovf),      32'(m_ovf));
    end
  end

  task automatic applyStimulus(input logic t, input logic [7:0] d);
    @(negedge clk);
    trmt    = t;
    tx_data = d;
  endtask

  int         k;
  int         bi;
  int         done_m, done_e, done_o, done_s;
  logic [9:0] got_m, got_s;
  logic [10:0] got_e, got_o;
  logic [7:0] burst [6];
  int         ptime [8];
  int         np;
  int         max_cnt;
  int         prob;

  initial begin
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (ptime[i]) ptime[i] = 0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx",   32'(tx_m),          32'd1);
    checkOutput("rst_rdy",  32'(if_m.tx_rdy),   32'd1);
    checkOutput("rst_busy", 32'(if_m.busy),     32'd0);
    checkOutput("rst_cnt",  32'(if_m.fifo_cnt), 32'd0);
    checkOutput("rst_ovf",  32'(if_m.ovf),      32'd0);
    checkOutput("rst_done", 32'(if_m.tx_done),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames on all four instances at once
    @(negedge clk);
    trmt = 1'b1; tx_data = 8'hA5;
    aux_trmt = 1'b1; aux_data8 = 8'hA5; aux_data7 = 7'h41;
    @(negedge clk);
    trmt = 1'b0; aux_trmt = 1'b0;
    k = 0;
    while (tx_m !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("start_seen", 32'(k < 10), 32'd1);
    done_m = -1; done_e = -1; done_o = -1; done_s = -1;
    got_m = '0; got_s = '0; got_e = '0; got_o = '0;
    for (int c = 0; c < 48; c++) begin
      if (c % 4 == 2) begin
        bi = c / 4;
        if (bi < 10) begin
          got_m[bi] = tx_m;
          got_s[bi] = tx_s;
        end
        if (bi < 11) begin
          got_e[bi] = tx_e;
          got_o[bi] = tx_o;
        end
      end
      if (if_m.tx_done === 1'b1 && done_m < 0) done_m = c;
      if (if_e.tx_done === 1'b1 && done_e < 0) done_e = c;
      if (if_o.tx_done === 1'b1 && done_o < 0) done_o = c;
      if (if_s.tx_done === 1'b1 && done_s < 0) done_s = c;
      if (c == 41) checkOutput("busy_after_frame", 32'(if_m.busy), 32'd0);
      @(negedge clk);
    end
    checkOutput("frame_8n1", 32'(got_m), 32'b1101001010);
    checkOutput("frame_8e1", 32'(got_e), 32'b10101001010);
    checkOutput("frame_8o1", 32'(got_o), 32'b11101001010);
    checkOutput("frame_7n2", 32'(got_s), 32'b1110000010);
    checkOutput("done_8n1",  32'(done_m), 32'd40);
    checkOutput("done_8e1",  32'(done_e), 32'd44);
    checkOutput("done_8o1",  32'(done_o), 32'd44);
    checkOutput("done_7n2",  32'(done_s), 32'd40);

    // Five-word burst, then a sixth push against a full FIFO
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        checkOutput("burst_ovf_before", 32'(if_m.ovf),      32'd0);
        checkOutput("burst_cnt_full",   32'(if_m.fifo_cnt), 32'd4);
        checkOutput("burst_rdy_low",    32'(if_m.tx_rdy),   32'd0);
      end
      trmt    = 1'b1;
      tx_data = burst[i];
    end
    @(negedge clk);
    trmt = 1'b0;
    checkOutput("burst_ovf_after", 32'(if_m.ovf),      32'd1);
    checkOutput("burst_cnt_after", 32'(if_m.fifo_cnt), 32'd4);
    np = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (if_m.tx_done === 1'b1) begin
        if (np < 8) ptime[np] = c;
        np++;
      end
    end
    checkOutput("burst_pulses", 32'(np), 32'd5);
    for (int i = 1; i < 5; i++) checkOutput("burst_spacing", 32'(ptime[i] - ptime[i-1]), 32'd40);

    // Reset in the middle of data bit 3 with two words still queued
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b1, 8'h96);
    applyStimulus(1'b0, 8'h00);
    repeat (16) @(negedge clk);
    checkOutput("pre_rst_cnt",  32'(if_m.fifo_cnt), 32'd2);
    checkOutput("pre_rst_bit3", 32'(tx_m),          32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_tx",   32'(tx_m),          32'd1);
    checkOutput("mid_rst_cnt",  32'(if_m.fifo_cnt), 32'd0);
    checkOutput("mid_rst_busy", 32'(if_m.busy),     32'd0);
    checkOutput("mid_rst_ovf",  32'(if_m.ovf),      32'd0);
    rst = 1'b0;
    np = 0;
    k  = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (if_m.tx_done === 1'b1) np++;
      if (tx_m !== 1'b1) k++;
    end
    checkOutput("post_rst_pulses", 32'(np), 32'd0);
    checkOutput("post_rst_line",   32'(k),  32'd0);

    // trmt held high continuously
    max_cnt = 0;
    for (int c = 0; c < 250; c++) begin
      applyStimulus(1'b1, 8'($urandom));
      if (int'(if_m.fifo_cnt) > max_cnt) max_cnt = int'(if_m.fifo_cnt);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("held_cnt_max", 32'(max_cnt), 32'd4);
    checkOutput("held_ovf",     32'(if_m.ovf), 32'd1);

    // Randomised traffic with varying load and occasional reset
    prob = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 3))
          0:       prob = 5;
          1:       prob = 20;
          2:       prob = 60;
          default: prob = 95;
        endcase
      end
      @(negedge clk);
      trmt    = ($urandom_range(0, 99) < prob);
      tx_data = 8'($urandom);
      rst     = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    trmt = 1'b0;
    rst  = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("drained_busy", 32'(if_m.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
